embnew16k_memtest_master: RTL and testbench

Avalon-MM initiator that fills a word range of the 4096×32 on-chip RAM slave with a deterministic pattern, reads it back, and reports mismatches. Sits beside the Nios/fabric master on the same on-chip memory port (through the interconnect arbiter, or directly during bring-up) and is controlled by a start/done handshake from a CSR block. It drives the slave's native signals: `address`, `byteenable`, `chipselect`, `write`, `writedata`, `clken`, `readdata`. The slave has no waitrequest and a fixed read latency.

---
 rtl/embnew16k_memtest_pkg.sv | 16 +
 rtl/embnew16k_memtest_pipe.sv | 48 ++++
 rtl/embnew16k_memtest_master.sv | 166 ++++++++++++++++
 tb/tb_embnew16k_memtest_master.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/embnew16k_memtest_pkg.sv
// Shared constants and state encoding for the on-chip RAM memory-test initiator.
package embnew16k_memtest_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned MAX_WORDS  = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/embnew16k_memtest_pipe.sv
// Valid + address + expected-data delay line matching the RAM read latency.
module embnew16k_memtest_pipe
  import embnew16k_memtest_pkg::*;
#(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Payload needs no reset: it is only consumed alongside its valid bit.
  always_ff @(posedge clk_i) begin
    addr_q[0] <= addr_i;
    data_q[0] <= data_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      addr_q[i] <= addr_q[i-1];
      data_q[i] <= data_q[i-1];
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign addr_o  = addr_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/embnew16k_memtest_master.sv
// Avalon-MM initiator: writes seed+i to base+i, reads back, counts mismatches.
module embnew16k_memtest_master
  import embnew16k_memtest_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata
);

  localparam int unsigned     MaxN      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MaxNW     = (ADDR_W+1)'(MaxN);
  localparam logic [ADDR_W:0] One       = (ADDR_W+1)'(1);
  localparam logic [1:0]      DrainLast = 2'(READ_LATENCY - 1);

  state_e            state_q;
  logic [ADDR_W:0]   n_q, idx_q, err_q, n_clamp_d, err_d;
  logic [ADDR_W-1:0] base_q, addr_q, ferr_q;
  logic [DATA_W-1:0] seed_q, data_q;
  logic              cs_q, wr_q, busy_q, done_q, pass_q;
  logic [1:0]        drain_q;
  logic              pipe_valid, miss_d;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;

  // Delay line is fed from the registered bus so it lines up with RAM latency.
  embnew16k_memtest_pipe #(
    .DEPTH  (READ_LATENCY),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .valid_i (cs_q & ~wr_q),
    .addr_i  (addr_q),
    .data_i  (data_q),
    .valid_o (pipe_valid),
    .addr_o  (pipe_addr),
    .data_o  (pipe_data)
  );

  always_comb begin
    n_clamp_d = (num_words > MaxNW) ? MaxNW : num_words;
    miss_d    = pipe_valid && (m_readdata != pipe_data);
    err_d     = err_q + (ADDR_W+1)'(miss_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      ferr_q  <= '0;
      seed_q  <= '0;
      data_q  <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      drain_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (miss_d) begin
        err_q <= err_d;
        if (err_q == '0) ferr_q <= pipe_addr;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            seed_q <= seed;
            n_q    <= n_clamp_d;
            err_q  <= '0;
            ferr_q <= '0;
            addr_q <= base_addr;
            data_q <= seed;
            idx_q  <= One;
            if (n_clamp_d == '0) begin
              pass_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              pass_q  <= 1'b0;
              busy_q  <= 1'b1;
              cs_q    <= 1'b1;
              wr_q    <= 1'b1;
              state_q <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (idx_q == n_q) begin
            wr_q    <= 1'b0;
            addr_q  <= base_q;
            data_q  <= seed_q;
            idx_q   <= One;
            state_q <= ST_READ;
          end else begin
            addr_q <= addr_q + 1'b1;
            data_q <= data_q + 1'b1;
            idx_q  <= idx_q + 1'b1;
          end
        end
        ST_READ: begin
          if (idx_q == n_q) begin
            cs_q    <= 1'b0;
            drain_q <= '0;
            state_q <= ST_DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
            data_q <= data_q + 1'b1;
            idx_q  <= idx_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          // The last compare lands in this cycle, so pass uses the next count.
          if (drain_q == DrainLast) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= ST_DONE;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign m_address      = addr_q;
  assign m_chipselect   = cs_q;
  assign m_write        = wr_q;
  assign m_byteenable   = 4'hF;
  assign m_writedata    = data_q;
  assign m_clken        = 1'b1;

endmodule

// File: tb/tb_embnew16k_memtest_master.sv
// Bench: two DUTs (read latency 1 and 3) against behavioural RAMs, vector table plus reset/glitch sequences.
module tb_embnew16k_memtest_master;
  import embnew16k_memtest_pkg::*;

  typedef struct {
    logic [11:0] base;
    logic [12:0] n;
    logic [31:0] seed;
    logic        stuck;
    int          glitch;
    int          exp_n;
    logic [12:0] exp_err;
    logic [11:0] exp_ferr;
    logic        exp_pass;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] num_words = '0;
  logic [31:0] seed = '0;
  logic        stuck = 1'b0;

  logic        busy [2], done [2], pass [2], cs [2], wr [2], clken [2];
  logic [12:0] errc [2];
  logic [11:0] ferr [2], addr [2];
  logic [3:0]  be [2];
  logic [31:0] wdata [2], rdata [2];

  embnew16k_memtest_master #(.ADDR_W(12), .DATA_W(32), .READ_LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(errc[0]), .first_err_addr(ferr[0]),
    .m_address(addr[0]), .m_chipselect(cs[0]), .m_write(wr[0]),
    .m_byteenable(be[0]), .m_writedata(wdata[0]), .m_clken(clken[0]),
    .m_readdata(rdata[0])
  );

  embnew16k_memtest_master #(.ADDR_W(12), .DATA_W(32), .READ_LATENCY(3)) dut_l3 (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(errc[1]), .first_err_addr(ferr[1]),
    .m_address(addr[1]), .m_chipselect(cs[1]), .m_write(wr[1]),
    .m_byteenable(be[1]), .m_writedata(wdata[1]), .m_clken(clken[1]),
    .m_readdata(rdata[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Behavioural RAMs; bit 3 of word 0x005 reads stuck-at-1 when 'stuck' is set.
  logic [31:0] mem [2][4096];
  logic [31:0] rdq [2][3];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cs[d] && wr[d]) mem[d][addr[d]] <= wdata[d];
      rdq[d][0] <= mem[d][addr[d]] | ((stuck && addr[d] == 12'h005) ? 32'h8 : 32'h0);
      rdq[d][1] <= rdq[d][0];
      rdq[d][2] <= rdq[d][1];
    end
  end
  assign rdata[0] = rdq[0][0];
  assign rdata[1] = rdq[1][2];

  // Bus monitor: counts accesses and flags any out-of-order address, data or cycle.
  int          gen = 0, t0 = 0, mon_n = 0;
  logic [11:0] mon_base = '0;
  logic [31:0] mon_seed = '0;
  int          last_gen = 0;
  int          wcnt [2], rcnt [2], dcnt [2], dcyc [2], sbad [2];
  logic        pass_s [2];
  logic [12:0] err_s [2];
  logic [11:0] ferr_s [2];

  always @(negedge clk) begin
    if (last_gen != gen) begin
      last_gen = gen;
      for (int d = 0; d < 2; d++) begin
        wcnt[d] = 0; rcnt[d] = 0; dcnt[d] = 0; dcyc[d] = -1; sbad[d] = 0;
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (cs[d]) begin
        if (!busy[d] || be[d] != 4'hF || !clken[d]) sbad[d]++;
        if (wr[d]) begin
          if (addr[d] != 12'(mon_base + wcnt[d]) || wdata[d] != 32'(mon_seed + wcnt[d])
              || cyc != t0 + 1 + wcnt[d]) sbad[d]++;
          wcnt[d]++;
        end else begin
          if (addr[d] != 12'(mon_base + rcnt[d]) || cyc != t0 + 1 + mon_n + rcnt[d]) sbad[d]++;
          rcnt[d]++;
        end
      end
      if (done[d]) begin
        dcnt[d]++;
        dcyc[d]   = cyc;
        pass_s[d] = pass[d];
        err_s[d]  = errc[d];
        ferr_s[d] = ferr[d];
        if (busy[d]) sbad[d]++;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic start_run(input vec_t v);
    @(negedge clk);
    base_addr = v.base;
    num_words = v.n;
    seed      = v.seed;
    stuck     = v.stuck;
    mon_base  = v.base;
    mon_seed  = v.seed;
    mon_n     = v.exp_n;
    t0        = cyc;
    gen       = gen + 1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input vec_t v, input int idx);
    int exp_done;
    for (int d = 0; d < 2; d++)
      check($sformatf("v%0d.d%0d.busy_t1", idx, d), busy[d], (v.exp_n != 0));
    for (int i = 0; i < 2 * v.exp_n + 40; i++) begin
      @(negedge clk);
      if (v.glitch != 0 && cyc == t0 + v.glitch) begin
        start = 1'b1; base_addr = 12'h000; num_words = 13'd3;
      end else begin
        start = 1'b0;
      end
      if (dcnt[0] > 0 && dcnt[1] > 0) break;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      exp_done = (v.exp_n == 0) ? t0 + 1 : t0 + 1 + 2 * v.exp_n + lat(d);
      check($sformatf("v%0d.d%0d.done_pulses", idx, d), dcnt[d], 1);
      check($sformatf("v%0d.d%0d.done_cycle", idx, d), dcyc[d], exp_done);
      check($sformatf("v%0d.d%0d.pass", idx, d), pass_s[d], v.exp_pass);
      check($sformatf("v%0d.d%0d.err_count", idx, d), err_s[d], v.exp_err);
      check($sformatf("v%0d.d%0d.first_err", idx, d), ferr_s[d], v.exp_ferr);
      check($sformatf("v%0d.d%0d.writes", idx, d), wcnt[d], v.exp_n);
      check($sformatf("v%0d.d%0d.reads", idx, d), rcnt[d], v.exp_n);
      check($sformatf("v%0d.d%0d.bus_seq", idx, d), sbad[d], 0);
      check($sformatf("v%0d.d%0d.busy_after", idx, d), busy[d], 1'b0);
      check($sformatf("v%0d.d%0d.pass_hold", idx, d), pass[d], v.exp_pass);
    end
  endtask

  vec_t vt [8];
  vec_t rv, cv;

  initial begin
    //        base     n         seed           stk glt exp_n err     ferr     pass
    vt[0] = '{12'h000, 13'd16,   32'h1000_0000, 0,  0,  16,   13'd0, 12'h000, 1'b1};
    vt[1] = '{12'hFFE, 13'd4,    32'hA5A5_0000, 0,  0,  4,    13'd0, 12'h000, 1'b1};
    vt[2] = '{12'h000, 13'd8,    32'h0000_0000, 1,  0,  8,    13'd1, 12'h005, 1'b0};
    vt[3] = '{12'h000, 13'd8,    32'h0000_0008, 1,  0,  8,    13'd0, 12'h000, 1'b1};
    vt[4] = '{12'h123, 13'd0,    32'hDEAD_BEEF, 0,  0,  0,    13'd0, 12'h000, 1'b1};
    vt[5] = '{12'hFFC, 13'd16,   32'hFFFF_FFF8, 1,  0,  16,   13'd1, 12'h005, 1'b0};
    vt[6] = '{12'h040, 13'd20,   32'h0000_0055, 0,  23, 20,   13'd0, 12'h000, 1'b1};
    vt[7] = '{12'h800, 13'd5000, 32'h0BAD_0000, 0,  0,  MAX_WORDS, 13'd0, 12'h000, 1'b1};

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst.d%0d.busy", d), busy[d], 1'b0);
      check($sformatf("rst.d%0d.done", d), done[d], 1'b0);
      check($sformatf("rst.d%0d.pass", d), pass[d], 1'b0);
      check($sformatf("rst.d%0d.err", d), errc[d], 13'd0);
      check($sformatf("rst.d%0d.ferr", d), ferr[d], 12'd0);
      check($sformatf("rst.d%0d.addr", d), addr[d], 12'd0);
      check($sformatf("rst.d%0d.cs", d), cs[d], 1'b0);
      check($sformatf("rst.d%0d.wr", d), wr[d], 1'b0);
      check($sformatf("rst.d%0d.wdata", d), wdata[d], 32'd0);
      check($sformatf("rst.d%0d.be", d), be[d], 4'hF);
      check($sformatf("rst.d%0d.clken", d), clken[d], 1'b1);
    end
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      start_run(vt[i]);
      finish_run(vt[i], i);
    end

    // Reset asserted during write 5, then a clean run.
    rv = '{12'h000, 13'd16, 32'h0000_0000, 0, 0, 16, 13'd0, 12'h000, 1'b1};
    start_run(rv);
    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("mid.d%0d.cs_before", d), cs[d], 1'b1);
      check($sformatf("mid.d%0d.addr_before", d), addr[d], 12'h005);
    end
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("mid.d%0d.cs_async", d), cs[d], 1'b0);
      check($sformatf("mid.d%0d.busy_async", d), busy[d], 1'b0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("post.d%0d.c%0d.busy", d, k), busy[d], 1'b0);
        check($sformatf("post.d%0d.c%0d.done", d, k), done[d], 1'b0);
        check($sformatf("post.d%0d.c%0d.cs", d, k), cs[d], 1'b0);
      end
    end
    cv = '{12'h010, 13'd10, 32'h0000_0077, 0, 0, 10, 13'd0, 12'h000, 1'b1};
    start_run(cv);
    finish_run(cv, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1);
  end

endmodule
